// File: rtl/fpu_defs.sv
// Shared FPU definitions: operand/command widths, command codes, flag layout
// and the request-controller state encoding.
package fpu_defs;

  localparam int C_OP    = 32;
  localparam int C_CMD   = 4;
  localparam int C_RM    = 2;
  localparam int C_FLAGS = 6;

  localparam logic [C_CMD-1:0] C_FPU_ADD_CMD = 4'h0;
  localparam logic [C_CMD-1:0] C_FPU_SUB_CMD = 4'h1;
  localparam logic [C_CMD-1:0] C_FPU_MUL_CMD = 4'h2;
  localparam logic [C_CMD-1:0] C_FPU_I2F_CMD = 4'h3;
  localparam logic [C_CMD-1:0] C_FPU_F2I_CMD = 4'h4;

  localparam logic [C_OP-1:0] F_QNAN = 32'h7FC0_0000;

  // Flag vector is {OF, UF, Zero, IX, IV, Inf}, MSB first
  localparam int C_FLAG_OF   = 5;
  localparam int C_FLAG_UF   = 4;
  localparam int C_FLAG_ZERO = 3;
  localparam int C_FLAG_IX   = 2;
  localparam int C_FLAG_IV   = 1;
  localparam int C_FLAG_INF  = 0;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } fpu_req_state_t;

  function automatic logic [C_FLAGS-1:0] flag_bit(input int idx);
    logic [C_FLAGS-1:0] mask;
    mask      = '0;
    mask[idx] = 1'b1;
    return mask;
  endfunction

endpackage

// File: rtl/fpu_flag_acc.sv
// Sticky exception-flag accumulator; a clear coinciding with a capture
// keeps only the newly captured flags.
module fpu_flag_acc
  import fpu_defs::*;
(
  input  logic               Clk_CI,
  input  logic               Rst_RI,
  input  logic               Capture_SI,
  input  logic [C_FLAGS-1:0] Flags_DI,
  input  logic               Clr_SI,
  output logic [C_FLAGS-1:0] Sticky_DO
);

  logic [C_FLAGS-1:0] sticky_q;

  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      sticky_q <= '0;
    end else if (Clr_SI && Capture_SI) begin
      sticky_q <= Flags_DI;
    end else if (Clr_SI) begin
      sticky_q <= '0;
    end else if (Capture_SI) begin
      sticky_q <= sticky_q | Flags_DI;
    end
  end

  assign Sticky_DO = sticky_q;

endmodule

// File: rtl/fpu_req_ctrl.sv
// Request-side FPU controller: req/gnt in, rvalid/rready out, with a valid
// watchdog. Define FPU_STICKY_FLAGS_EN to build in the sticky flag register.
module fpu_req_ctrl
  import fpu_defs::*;
#(
  parameter int C_TAG_W   = 2,
  parameter int C_TIMEOUT = 4
) (
  input  logic               Clk_CI,
  input  logic               Rst_RI,
  input  logic               Req_SI,
  output logic               Gnt_SO,
  input  logic [C_OP-1:0]    OpA_DI,
  input  logic [C_OP-1:0]    OpB_DI,
  input  logic [C_CMD-1:0]   OP_SI,
  input  logic [C_RM-1:0]    RM_SI,
  input  logic [C_TAG_W-1:0] Tag_DI,
  output logic               Rvalid_SO,
  input  logic               Rready_SI,
  output logic [C_OP-1:0]    Result_DO,
  output logic [C_FLAGS-1:0] Flags_DO,
  output logic [C_TAG_W-1:0] Tag_DO,
  output logic               Err_DO,
  output logic               FpuEnable_SO,
  output logic [C_OP-1:0]    FpuOpA_DO,
  output logic [C_OP-1:0]    FpuOpB_DO,
  output logic [C_CMD-1:0]   FpuOP_SO,
  output logic [C_RM-1:0]    FpuRM_SO,
  input  logic [C_OP-1:0]    FpuResult_DI,
  input  logic               FpuValid_SI,
  input  logic [C_FLAGS-1:0] FpuFlags_DI,
  input  logic               FlagsClr_SI,
  output logic [C_FLAGS-1:0] FlagsSticky_DO,
  output logic               Busy_SO
);

  localparam int C_CNT_W = (C_TIMEOUT > 1) ? $clog2(C_TIMEOUT) : 1;
  localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(C_TIMEOUT - 1);

  fpu_req_state_t     state_q;
  logic [C_CNT_W-1:0] cnt_q;
  logic [C_TAG_W-1:0] tag_q;
  logic [C_OP-1:0]    result_q;
  logic [C_FLAGS-1:0] flags_q;
  logic               err_q;
  logic               rvalid_q;

  logic               gnt;
  logic               wait_valid;
  logic               wait_timeout;
  logic               capture;
  logic [C_FLAGS-1:0] capture_flags;

  // A new request is accepted from IDLE, or from RESP in the same cycle the
  // pending response is consumed; never while reset is held.
  assign gnt = !Rst_RI && Req_SI &&
               ((state_q == IDLE) || ((state_q == RESP) && Rready_SI));

  assign wait_valid    = (state_q == WAIT) && FpuValid_SI;
  assign wait_timeout  = (state_q == WAIT) && !FpuValid_SI && (cnt_q == C_CNT_LAST);
  assign capture       = wait_valid || wait_timeout;
  assign capture_flags = wait_valid ? FpuFlags_DI : flag_bit(C_FLAG_IV);

  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      tag_q    <= '0;
      result_q <= '0;
      flags_q  <= '0;
      err_q    <= 1'b0;
      rvalid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt) begin
            state_q <= WAIT;
            cnt_q   <= '0;
            tag_q   <= Tag_DI;
          end
        end
        WAIT: begin
          if (capture) begin
            result_q <= wait_valid ? FpuResult_DI : F_QNAN;
            flags_q  <= capture_flags;
            err_q    <= wait_timeout;
            rvalid_q <= 1'b1;
            state_q  <= RESP;
          end else begin
            cnt_q <= cnt_q + C_CNT_W'(1);
          end
        end
        RESP: begin
          if (Rready_SI) begin
            rvalid_q <= 1'b0;
            if (gnt) begin
              state_q <= WAIT;
              cnt_q   <= '0;
              tag_q   <= Tag_DI;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign Gnt_SO       = gnt;
  assign FpuEnable_SO = gnt;
  assign FpuOpA_DO    = OpA_DI;
  assign FpuOpB_DO    = OpB_DI;
  assign FpuOP_SO     = OP_SI;
  assign FpuRM_SO     = RM_SI;

  assign Rvalid_SO = rvalid_q;
  assign Result_DO = result_q;
  assign Flags_DO  = flags_q;
  assign Tag_DO    = tag_q;
  assign Err_DO    = err_q;
  assign Busy_SO   = (state_q != IDLE);

`ifdef FPU_STICKY_FLAGS_EN
  fpu_flag_acc i_flag_acc (
    .Clk_CI     (Clk_CI),
    .Rst_RI     (Rst_RI),
    .Capture_SI (capture),
    .Flags_DI   (capture_flags),
    .Clr_SI     (FlagsClr_SI),
    .Sticky_DO  (FlagsSticky_DO)
  );
`else
  logic unused_flags_clr;
  assign unused_flags_clr = FlagsClr_SI;
  assign FlagsSticky_DO   = '0;
`endif

endmodule

// File: tb/tb_fpu_req_ctrl.sv
// Directed bench for fpu_req_ctrl with a one-cycle-latency FPU core model.
module tb_fpu_req_ctrl;
  import fpu_defs::*;

  localparam int C_TAG_W = 2;

`ifdef FPU_STICKY_FLAGS_EN
  localparam logic [5:0] EXP_STICKY_OF_IX = 6'b100100;
  localparam logic [5:0] EXP_STICKY_CLR   = 6'b000010;
`else
  localparam logic [5:0] EXP_STICKY_OF_IX = 6'b000000;
  localparam logic [5:0] EXP_STICKY_CLR   = 6'b000000;
`endif

  logic               Clk_CI = 1'b0;
  logic               Rst_RI;
  logic               Req_SI;
  logic               Gnt_SO;
  logic [C_OP-1:0]    OpA_DI, OpB_DI;
  logic [C_CMD-1:0]   OP_SI;
  logic [C_RM-1:0]    RM_SI;
  logic [C_TAG_W-1:0] Tag_DI;
  logic               Rvalid_SO;
  logic               Rready_SI;
  logic [C_OP-1:0]    Result_DO;
  logic [5:0]         Flags_DO;
  logic [C_TAG_W-1:0] Tag_DO;
  logic               Err_DO;
  logic               FpuEnable_SO;
  logic [C_OP-1:0]    FpuOpA_DO, FpuOpB_DO;
  logic [C_CMD-1:0]   FpuOP_SO;
  logic [C_RM-1:0]    FpuRM_SO;
  logic [C_OP-1:0]    FpuResult_DI;
  logic               FpuValid_SI;
  logic [5:0]         FpuFlags_DI;
  logic               FlagsClr_SI;
  logic [5:0]         FlagsSticky_DO;
  logic               Busy_SO;

  // Core model controls and registers
  logic        core_on      = 1'b0;
  logic        model_echo   = 1'b0;
  logic        stray_valid  = 1'b0;
  logic [31:0] model_result = '0;
  logic [5:0]  model_flags  = '0;
  logic        core_valid_q = 1'b0;
  logic [31:0] core_result_q = '0;
  logic [5:0]  core_flags_q  = '0;

  int vectors    = 0;
  int miscompares = 0;

  always #5 Clk_CI = ~Clk_CI;

  fpu_req_ctrl #(.C_TAG_W(C_TAG_W), .C_TIMEOUT(4)) dut (
    .Clk_CI         (Clk_CI),
    .Rst_RI         (Rst_RI),
    .Req_SI         (Req_SI),
    .Gnt_SO         (Gnt_SO),
    .OpA_DI         (OpA_DI),
    .OpB_DI         (OpB_DI),
    .OP_SI          (OP_SI),
    .RM_SI          (RM_SI),
    .Tag_DI         (Tag_DI),
    .Rvalid_SO      (Rvalid_SO),
    .Rready_SI      (Rready_SI),
    .Result_DO      (Result_DO),
    .Flags_DO       (Flags_DO),
    .Tag_DO         (Tag_DO),
    .Err_DO         (Err_DO),
    .FpuEnable_SO   (FpuEnable_SO),
    .FpuOpA_DO      (FpuOpA_DO),
    .FpuOpB_DO      (FpuOpB_DO),
    .FpuOP_SO       (FpuOP_SO),
    .FpuRM_SO       (FpuRM_SO),
    .FpuResult_DI   (FpuResult_DI),
    .FpuValid_SI    (FpuValid_SI),
    .FpuFlags_DI    (FpuFlags_DI),
    .FlagsClr_SI    (FlagsClr_SI),
    .FlagsSticky_DO (FlagsSticky_DO),
    .Busy_SO        (Busy_SO)
  );

  // Core answers one cycle after each enable
  always @(posedge Clk_CI) begin
    core_valid_q  <= FpuEnable_SO && core_on;
    core_result_q <= model_echo ? FpuOpA_DO : model_result;
    core_flags_q  <= model_flags;
  end

  assign FpuValid_SI  = core_valid_q | stray_valid;
  assign FpuResult_DI = core_result_q;
  assign FpuFlags_DI  = core_flags_q;

  task automatic tick();
    @(posedge Clk_CI);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  // One complete transaction with the core answering and Rready held high
  task automatic applyStimulus(input logic [C_TAG_W-1:0] tag, input logic [5:0] flags);
    Req_SI      = 1'b1;
    Tag_DI      = tag;
    model_flags = flags;
    tick();
    Req_SI = 1'b0;
    tick();
    checkOutput("txn_rvalid", 32'(Rvalid_SO), 32'd1);
    checkOutput("txn_flags", 32'(Flags_DO), 32'(flags));
    tick();
  endtask

  initial begin
    Rst_RI = 1'b1; Req_SI = 1'b1; OpA_DI = '0; OpB_DI = '0; OP_SI = '0; RM_SI = '0;
    Tag_DI = '0; Rready_SI = 1'b0; FlagsClr_SI = 1'b0;
    tick(); tick();
    $display("[TB] reset values");
    checkOutput("rst_gnt", 32'(Gnt_SO), 32'd0);
    checkOutput("rst_enable", 32'(FpuEnable_SO), 32'd0);
    checkOutput("rst_rvalid", 32'(Rvalid_SO), 32'd0);
    checkOutput("rst_busy", 32'(Busy_SO), 32'd0);
    checkOutput("rst_result", Result_DO, 32'd0);
    checkOutput("rst_flags", 32'(Flags_DO), 32'd0);
    checkOutput("rst_tag", 32'(Tag_DO), 32'd0);
    checkOutput("rst_err", 32'(Err_DO), 32'd0);
    checkOutput("rst_sticky", 32'(FlagsSticky_DO), 32'd0);
    Req_SI = 1'b0; Rst_RI = 1'b0;
    tick();

    $display("[TB] single ADD");
    Req_SI = 1'b1; OpA_DI = 32'h3F80_0000; OpB_DI = 32'h4000_0000; OP_SI = C_FPU_ADD_CMD;
    RM_SI = 2'd1; Tag_DI = 2'd1; model_result = 32'h4040_0000; model_flags = '0; core_on = 1'b1;
    #1;
    checkOutput("add_gnt", 32'(Gnt_SO), 32'd1);
    checkOutput("add_enable", 32'(FpuEnable_SO), 32'd1);
    checkOutput("add_fpu_opa", FpuOpA_DO, 32'h3F80_0000);
    checkOutput("add_fpu_opb", FpuOpB_DO, 32'h4000_0000);
    checkOutput("add_fpu_op", 32'(FpuOP_SO), 32'(C_FPU_ADD_CMD));
    checkOutput("add_fpu_rm", 32'(FpuRM_SO), 32'd1);
    tick();
    Req_SI = 1'b0;
    #1;
    checkOutput("add_wait_enable", 32'(FpuEnable_SO), 32'd0);
    checkOutput("add_wait_busy", 32'(Busy_SO), 32'd1);
    checkOutput("add_wait_rvalid", 32'(Rvalid_SO), 32'd0);
    tick();
    checkOutput("add_rvalid", 32'(Rvalid_SO), 32'd1);
    checkOutput("add_result", Result_DO, 32'h4040_0000);
    checkOutput("add_tag", 32'(Tag_DO), 32'd1);
    checkOutput("add_err", 32'(Err_DO), 32'd0);
    Rready_SI = 1'b1;
    tick();
    checkOutput("add_idle_rvalid", 32'(Rvalid_SO), 32'd0);
    checkOutput("add_idle_busy", 32'(Busy_SO), 32'd0);

    $display("[TB] back-to-back MUL");
    OP_SI = C_FPU_MUL_CMD; model_echo = 1'b1;
    for (int i = 0; i < 4; i++) begin
      Req_SI = 1'b1; Tag_DI = 2'(i); OpA_DI = 32'h1000_0000 + 32'(i);
      #1;
      checkOutput("b2b_gnt", 32'(Gnt_SO), 32'd1);
      tick();
      checkOutput("b2b_wait_gnt", 32'(Gnt_SO), 32'd0);
      checkOutput("b2b_wait_rvalid", 32'(Rvalid_SO), 32'd0);
      tick();
      checkOutput("b2b_result", Result_DO, 32'h1000_0000 + 32'(i));
      checkOutput("b2b_tag", 32'(Tag_DO), 32'(i));
    end
    Req_SI = 1'b0;
    tick();
    checkOutput("b2b_idle_busy", 32'(Busy_SO), 32'd0);

    $display("[TB] backpressure");
    Rready_SI = 1'b0; Req_SI = 1'b1; Tag_DI = 2'd2; OpA_DI = 32'hAAAA_0000;
    #1;
    checkOutput("bp_gnt", 32'(Gnt_SO), 32'd1);
    tick(); tick();
    Tag_DI = 2'd3; OpA_DI = 32'hBBBB_0000;
    for (int i = 0; i < 5; i++) begin
      #1;
      checkOutput("bp_hold_gnt", 32'(Gnt_SO), 32'd0);
      checkOutput("bp_hold_rvalid", 32'(Rvalid_SO), 32'd1);
      checkOutput("bp_hold_result", Result_DO, 32'hAAAA_0000);
      checkOutput("bp_hold_tag", 32'(Tag_DO), 32'd2);
      tick();
    end
    Rready_SI = 1'b1;
    #1;
    checkOutput("bp_release_gnt", 32'(Gnt_SO), 32'd1);
    tick();
    Req_SI = 1'b0;
    tick();
    checkOutput("bp_next_result", Result_DO, 32'hBBBB_0000);
    checkOutput("bp_next_tag", 32'(Tag_DO), 32'd3);
    tick();
    checkOutput("bp_idle_busy", 32'(Busy_SO), 32'd0);

    $display("[TB] watchdog timeout");
    core_on = 1'b0; model_echo = 1'b0; Rready_SI = 1'b0;
    Req_SI = 1'b1; Tag_DI = 2'd1; OP_SI = C_FPU_F2I_CMD;
    #1;
    checkOutput("to_gnt", 32'(Gnt_SO), 32'd1);
    tick();
    Req_SI = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      checkOutput("to_early_rvalid", 32'(Rvalid_SO), 32'd0);
      tick();
    end
    checkOutput("to_rvalid", 32'(Rvalid_SO), 32'd1);
    checkOutput("to_result", Result_DO, 32'h7FC0_0000);
    checkOutput("to_flags", 32'(Flags_DO), 32'h02);
    checkOutput("to_err", 32'(Err_DO), 32'd1);
    checkOutput("to_tag", 32'(Tag_DO), 32'd1);
    Rready_SI = 1'b1;
    tick();

    $display("[TB] sticky flags");
    core_on = 1'b1;
    FlagsClr_SI = 1'b1;
    tick();
    FlagsClr_SI = 1'b0;
    applyStimulus(2'd0, 6'b100000);
    applyStimulus(2'd1, 6'b000100);
    checkOutput("sticky_of_ix", 32'(FlagsSticky_DO), 32'(EXP_STICKY_OF_IX));
    Req_SI = 1'b1; model_flags = 6'b000010;
    tick();
    Req_SI = 1'b0; FlagsClr_SI = 1'b1;
    tick();
    FlagsClr_SI = 1'b0;
    checkOutput("sticky_clr_capture", 32'(FlagsSticky_DO), 32'(EXP_STICKY_CLR));
    tick();

    $display("[TB] reset during WAIT");
    core_on = 1'b0; Req_SI = 1'b1;
    tick();
    Req_SI = 1'b0; Rst_RI = 1'b1;
    tick();
    checkOutput("mid_rst_busy", 32'(Busy_SO), 32'd0);
    checkOutput("mid_rst_rvalid", 32'(Rvalid_SO), 32'd0);
    Rst_RI = 1'b0; stray_valid = 1'b1;
    tick();
    stray_valid = 1'b0;
    checkOutput("stray_busy", 32'(Busy_SO), 32'd0);
    checkOutput("stray_rvalid", 32'(Rvalid_SO), 32'd0);
    checkOutput("stray_sticky", 32'(FlagsSticky_DO), 32'd0);
    tick();
    checkOutput("post_stray_rvalid", 32'(Rvalid_SO), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
